// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath: IF/ID/EXE/MEM/WB (+HALT).
// Latency: 2..5 cycles per instruction plus one cycle per MEM wait; control outputs are combinational.
// Backpressure: holds MEM with MemRead/MemWrite asserted until mem_ready; halts on an illegal opcode.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [5:0]       OP,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             Jump,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             ExtSel,
    output logic [2:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_R, C_ADDIU, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_ILL
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t           state_q;
    cls_t             cls_q;
    logic [2:0]       rop_q;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;

    cls_t             dec_cls;
    logic [2:0]       dec_rop;

    // Decode the live instruction fields; only consumed while in ID.
    always_comb begin
        dec_cls = C_ILL;
        dec_rop = ALU_ADD;
        case (OP)
            6'h00: begin
                case (func)
                    6'h00:        dec_cls = C_NOP;
                    6'h20, 6'h21: begin dec_cls = C_R; dec_rop = ALU_ADD; end
                    6'h22, 6'h23: begin dec_cls = C_R; dec_rop = ALU_SUB; end
                    6'h24:        begin dec_cls = C_R; dec_rop = ALU_AND; end
                    6'h25:        begin dec_cls = C_R; dec_rop = ALU_OR;  end
                    6'h2A:        begin dec_cls = C_R; dec_rop = ALU_SLT; end
                    default:      dec_cls = C_ILL;
                endcase
            end
            6'h09:   dec_cls = C_ADDIU;
            6'h0D:   dec_cls = C_ORI;
            6'h23:   dec_cls = C_LW;
            6'h2B:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h02:   dec_cls = C_J;
            default: dec_cls = C_ILL;
        endcase
    end

    // Sequencer state, latched instruction class, sticky halt flag and retire counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IF;
            cls_q    <= C_NOP;
            rop_q    <= ALU_ADD;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (PCWrite) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_IF: state_q <= S_ID;
                S_ID: begin
                    cls_q <= dec_cls;
                    rop_q <= dec_rop;
                    case (dec_cls)
                        C_J, C_NOP: state_q <= S_IF;
                        C_ILL: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default:    state_q <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    case (cls_q)
                        C_BEQ:      state_q <= S_IF;
                        C_LW, C_SW: state_q <= S_MEM;
                        default:    state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= (cls_q == C_LW) ? S_WB : S_IF;
                    end
                end
                S_WB:    state_q <= S_IF;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IF;
            endcase
        end
    end

    // Per-state datapath controls; everything is forced low while reset is held.
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        ExtSel   = 1'b0;
        ALUOp    = ALU_ADD;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IF: IRWrite = 1'b1;
                S_ID: begin
                    if (dec_cls == C_J) begin
                        Jump    = 1'b1;
                        PCWrite = 1'b1;
                    end else if (dec_cls == C_NOP) begin
                        PCWrite = 1'b1;
                    end
                end
                S_EXE: begin
                    case (cls_q)
                        C_R:     ALUOp = rop_q;
                        C_ADDIU: begin ALUSrc = 1'b1; ExtSel = 1'b1; ALUOp = ALU_ADD; end
                        C_ORI:   begin ALUSrc = 1'b1; ALUOp = ALU_OR; end
                        C_LW, C_SW: begin ALUSrc = 1'b1; ExtSel = 1'b1; ALUOp = ALU_ADD; end
                        C_BEQ: begin
                            ALUOp   = ALU_SUB;
                            Branch  = 1'b1;
                            PCWrite = 1'b1;
                        end
                        default: ALUOp = ALU_ADD;
                    endcase
                end
                S_MEM: begin
                    // Keep the address computation stable for the whole access.
                    ALUSrc   = 1'b1;
                    ExtSel   = 1'b1;
                    ALUOp    = ALU_ADD;
                    MemRead  = (cls_q == C_LW);
                    MemWrite = (cls_q == C_SW);
                    PCWrite  = (cls_q == C_SW) && mem_ready;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    RegDst   = (cls_q == C_R);
                    MemToReg = (cls_q == C_LW);
                end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule
